// File: rtl/thread_regfile_if.sv
// Decode/ALU/LSU bus into one thread's register file and the operand/flag bus back out.
// master: core side (drives state, decode fields, data); slave: register file (drives rs, rt, nzp).
interface thread_regfile_if;
    logic       enable;
    logic [7:0] block_id;
    logic [2:0] core_state;
    logic [3:0] decoded_rd_address;
    logic [3:0] decoded_rs_address;
    logic [3:0] decoded_rt_address;
    logic       decoded_reg_write_enable;
    logic [1:0] decoded_reg_input_mux;
    logic [7:0] decoded_immediate;
    logic       decoded_nzp_write_enable;
    logic [7:0] alu_out;
    logic [7:0] lsu_out;
    logic [7:0] rs;
    logic [7:0] rt;
    logic [2:0] nzp;

    modport master (
        output enable, block_id, core_state,
        output decoded_rd_address, decoded_rs_address, decoded_rt_address,
        output decoded_reg_write_enable, decoded_reg_input_mux,
        output decoded_immediate, decoded_nzp_write_enable,
        output alu_out, lsu_out,
        input  rs, rt, nzp
    );

    modport slave (
        input  enable, block_id, core_state,
        input  decoded_rd_address, decoded_rs_address, decoded_rt_address,
        input  decoded_reg_write_enable, decoded_reg_input_mux,
        input  decoded_immediate, decoded_nzp_write_enable,
        input  alu_out, lsu_out,
        output rs, rt, nzp
    );
endinterface

// File: rtl/thread_regfile.sv
// Per-thread 16x8 register file with operand read (REQUEST), writeback and NZP capture (UPDATE).
// Ports: clk, reset (sync, active-high), bus (slave modport: decode/data in, rs/rt/nzp out).
module thread_regfile #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0
) (
    input logic             clk,
    input logic             reset,
    thread_regfile_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } core_state_t;

    logic [7:0] regs [16];
    logic [7:0] rs_q;
    logic [7:0] rt_q;
    logic [2:0] nzp_q;
    logic [7:0] wb_data;
    logic       wb_valid;
    core_state_t st;

    assign st      = core_state_t'(bus.core_state);
    assign bus.rs  = rs_q;
    assign bus.rt  = rt_q;
    assign bus.nzp = nzp_q;

    // Writeback source select; mux 11 and R13-R15 targets produce no write.
    always_comb begin
        wb_data  = bus.alu_out;
        wb_valid = 1'b0;
        case (bus.decoded_reg_input_mux)
            2'b00: begin wb_data = bus.alu_out;           wb_valid = 1'b1; end
            2'b01: begin wb_data = bus.lsu_out;           wb_valid = 1'b1; end
            2'b10: begin wb_data = bus.decoded_immediate; wb_valid = 1'b1; end
            default: begin wb_data = bus.alu_out;         wb_valid = 1'b0; end
        endcase
        if (!bus.decoded_reg_write_enable || bus.decoded_rd_address > 4'd12)
            wb_valid = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 14; i++)
                regs[i] <= '0;
            regs[14] <= 8'(THREADS_PER_BLOCK);
            regs[15] <= 8'(THREAD_ID);
            rs_q     <= '0;
            rt_q     <= '0;
            nzp_q    <= '0;
        end else if (bus.enable) begin
            case (st)
                S_IDLE: begin
                    regs[13] <= bus.block_id;
                end
                S_REQUEST: begin
                    rs_q <= regs[bus.decoded_rs_address];
                    rt_q <= regs[bus.decoded_rt_address];
                end
                S_UPDATE: begin
                    if (wb_valid)
                        regs[bus.decoded_rd_address] <= wb_data;
                    if (bus.decoded_nzp_write_enable)
                        nzp_q <= bus.alu_out[2:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_thread_regfile.sv
// Self-checking bench for thread_regfile: directed vector table, hand sequences, random vs model.
// Instantiates the DUT with THREADS_PER_BLOCK=4, THREAD_ID=2.
module tb_thread_regfile;
    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    thread_regfile_if bus_if ();

    thread_regfile #(
        .THREADS_PER_BLOCK(4),
        .THREAD_ID(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if)
    );

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, REQUEST = 3'd3;
    localparam logic [2:0] WAITS = 3'd4, EXEC = 3'd5, UPDATE = 3'd6, DONE = 3'd7;

    typedef struct {
        logic [2:0] st;
        logic [3:0] rd, ra, rb;
        logic       we;
        logic [1:0] mux;
        logic [7:0] imm, alu, lsu, blk;
        logic       nwe;
        logic [7:0] ers, ert;
        logic [2:0] enzp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [2:0] st, input logic [3:0] rd, input logic [3:0] ra,
        input logic [3:0] rb, input logic we, input logic [1:0] mux,
        input logic [7:0] imm, input logic [7:0] alu, input logic [7:0] lsu,
        input logic [7:0] blk, input logic nwe,
        input logic [7:0] ers, input logic [7:0] ert, input logic [2:0] enzp);
        vec_t v;
        v.st = st; v.rd = rd; v.ra = ra; v.rb = rb; v.we = we; v.mux = mux;
        v.imm = imm; v.alu = alu; v.lsu = lsu; v.blk = blk; v.nwe = nwe;
        v.ers = ers; v.ert = ert; v.enzp = enzp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus_if.core_state               = v.st;
        bus_if.decoded_rd_address       = v.rd;
        bus_if.decoded_rs_address       = v.ra;
        bus_if.decoded_rt_address       = v.rb;
        bus_if.decoded_reg_write_enable = v.we;
        bus_if.decoded_reg_input_mux    = v.mux;
        bus_if.decoded_immediate        = v.imm;
        bus_if.alu_out                  = v.alu;
        bus_if.lsu_out                  = v.lsu;
        bus_if.block_id                 = v.blk;
        bus_if.decoded_nzp_write_enable = v.nwe;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [7:0] ers,
                           input logic [7:0] ert, input logic [2:0] enzp);
        chk({name, "_rs"}, bus_if.rs, ers);
        chk({name, "_rt"}, bus_if.rt, ert);
        chk({name, "_nzp"}, {5'd0, bus_if.nzp}, {5'd0, enzp});
    endtask

    // Reference model: architectural state updated straight from the rules.
    logic [7:0] m_reg [16];
    logic [7:0] m_rs, m_rt;
    logic [2:0] m_nzp;

    task automatic model_reset();
        foreach (m_reg[i]) m_reg[i] = 8'd0;
        m_reg[14] = 8'd4;
        m_reg[15] = 8'd2;
        m_rs = 0; m_rt = 0; m_nzp = 0;
    endtask

    task automatic model_step(input logic rst, input logic en, input vec_t v);
        if (rst) begin
            model_reset();
        end else if (en) begin
            if (v.st == IDLE) m_reg[13] = v.blk;
            if (v.st == REQUEST) begin
                m_rs = m_reg[v.ra];
                m_rt = m_reg[v.rb];
            end
            if (v.st == UPDATE) begin
                if (v.we && v.rd <= 12 && v.mux != 2'b11)
                    m_reg[v.rd] = (v.mux == 2'b00) ? v.alu :
                                  (v.mux == 2'b01) ? v.lsu : v.imm;
                if (v.nwe) m_nzp = v.alu[2:0];
            end
        end
    endtask

    initial begin
        vec_t v;
        reset = 1'b1;
        bus_if.enable = 1'b1;
        drive(mk(FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        reset = 1'b0;
        chk_out("reset", 8'h00, 8'h00, 3'b000);

        //        st       rd  ra  rb  we mux imm    alu    lsu    blk  nwe ers    ert    nzp
        vecs.push_back(mk(REQUEST, 0,  0, 13, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 3'b000));
        vecs.push_back(mk(REQUEST, 0, 14, 15, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h04, 8'h02, 3'b000));
        vecs.push_back(mk(UPDATE,  3,  0,  0, 1, 0, 8'h11, 8'h2A, 8'h22, 0, 0, 8'h04, 8'h02, 3'b000));
        vecs.push_back(mk(UPDATE,  4,  0,  0, 1, 1, 8'h11, 8'h33, 8'h7F, 0, 0, 8'h04, 8'h02, 3'b000));
        vecs.push_back(mk(UPDATE,  5,  0,  0, 1, 2, 8'h05, 8'h33, 8'h22, 0, 0, 8'h04, 8'h02, 3'b000));
        vecs.push_back(mk(UPDATE,  6,  0,  0, 1, 3, 8'h99, 8'h99, 8'h99, 0, 0, 8'h04, 8'h02, 3'b000));
        vecs.push_back(mk(REQUEST, 0,  3,  4, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h2A, 8'h7F, 3'b000));
        vecs.push_back(mk(REQUEST, 0,  5,  6, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h05, 8'h00, 3'b000));
        vecs.push_back(mk(UPDATE, 15,  0,  0, 1, 2, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h05, 8'h00, 3'b000));
        vecs.push_back(mk(IDLE,    0,  1,  1, 0, 0, 8'h00, 8'h00, 8'h00, 9, 0, 8'h05, 8'h00, 3'b000));
        vecs.push_back(mk(FETCH,   0,  1,  1, 0, 0, 8'h00, 8'h00, 8'h00, 3, 0, 8'h05, 8'h00, 3'b000));
        vecs.push_back(mk(REQUEST, 0, 15, 13, 0, 0, 8'h00, 8'h00, 8'h00, 3, 0, 8'h02, 8'h09, 3'b000));
        vecs.push_back(mk(UPDATE, 13,  0,  0, 1, 2, 8'h77, 8'h00, 8'h00, 0, 0, 8'h02, 8'h09, 3'b000));
        vecs.push_back(mk(REQUEST, 0, 13, 14, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h09, 8'h04, 3'b000));
        vecs.push_back(mk(UPDATE,  0,  0,  0, 0, 0, 8'h00, 8'h04, 8'h00, 0, 1, 8'h09, 8'h04, 3'b100));
        vecs.push_back(mk(UPDATE,  0,  0,  0, 0, 0, 8'h00, 8'h01, 8'h00, 0, 0, 8'h09, 8'h04, 3'b100));
        vecs.push_back(mk(REQUEST, 0,  3,  4, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h2A, 8'h7F, 3'b100));
        vecs.push_back(mk(WAITS,   0,  5,  6, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h2A, 8'h7F, 3'b100));
        vecs.push_back(mk(EXEC,    0,  0, 15, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h2A, 8'h7F, 3'b100));
        vecs.push_back(mk(DONE,    3,  0, 15, 1, 2, 8'hEE, 8'h07, 8'h00, 0, 1, 8'h2A, 8'h7F, 3'b100));
        vecs.push_back(mk(DECODE,  3,  0, 15, 1, 0, 8'hEE, 8'h07, 8'h00, 0, 1, 8'h2A, 8'h7F, 3'b100));
        vecs.push_back(mk(REQUEST, 0,  3,  3, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h2A, 8'h2A, 3'b100));
        vecs.push_back(mk(UPDATE,  7,  0,  0, 1, 0, 8'h00, 8'hFA, 8'h00, 0, 1, 8'h2A, 8'h2A, 3'b010));
        vecs.push_back(mk(REQUEST, 0,  7, 12, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'hFA, 8'h00, 3'b010));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].ers, vecs[i].ert, vecs[i].enzp);
        end

        // Disabled UPDATE must not write R2; disabled REQUEST must not move rs/rt.
        bus_if.enable = 1'b0;
        drive(mk(UPDATE, 2, 0, 0, 1, 2, 8'h11, 8'h05, 0, 0, 1, 0, 0, 0));
        tick();
        chk_out("dis_upd", 8'hFA, 8'h00, 3'b010);
        drive(mk(REQUEST, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk_out("dis_req", 8'hFA, 8'h00, 3'b010);
        bus_if.enable = 1'b1;
        drive(mk(REQUEST, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk_out("en_req", 8'h00, 8'h00, 3'b010);

        // Write R2, then reset mid-instruction during EXECUTE.
        drive(mk(UPDATE, 2, 0, 0, 1, 2, 8'h11, 8'h00, 0, 0, 0, 0, 0, 0));
        tick();
        drive(mk(REQUEST, 0, 2, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk_out("r2_written", 8'h11, 8'h09, 3'b010);
        reset = 1'b1;
        drive(mk(EXEC, 2, 2, 2, 1, 2, 8'h55, 8'h00, 0, 0, 1, 0, 0, 0));
        tick();
        reset = 1'b0;
        chk_out("mid_reset", 8'h00, 8'h00, 3'b000);
        drive(mk(REQUEST, 0, 2, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk_out("post_reset", 8'h00, 8'h00, 3'b000);

        // Randomised run against the reference model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            logic r, e;
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 7) != 0);
            v = mk(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   1'($urandom_range(0, 1)), 0, 0, 0);
            reset = r;
            bus_if.enable = e;
            drive(v);
            tick();
            model_step(r, e, v);
            chk_out($sformatf("rnd%0d", c), m_rs, m_rt, m_nzp);
        end
        reset = 1'b0;
        bus_if.enable = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/thread_regfile.md
# thread_regfile

Per-thread register file and writeback stage of the compute core: one instance per thread, directly upstream and downstream of that thread's ALU. It supplies the `rs`/`rt` operands the ALU consumes in EXECUTE. In UPDATE it writes back the ALU result, load data or an immediate into the destination register. It also captures the ALU compare flags into the thread's NZP register for the branch logic.

## Interface
- `THREADS_PER_BLOCK`, default 4: value of read-only R14 (%blockDim).
- `THREAD_ID`, default 0: value of read-only R15 (%threadIdx).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high; clock `clk`.
- `enable`  in  1  thread active in current block; when low, no state changes.
- `block_id`  in  8  current block index.
- `core_state`  in  3  core FSM state: IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
- `decoded_rd_address`, `decoded_rs_address`, `decoded_rt_address`  in  4 each  register indices.
- `decoded_reg_write_enable`  in  1  instruction writes `rd`.
- `decoded_reg_input_mux`  in  2  writeback source: 00 ALU, 01 LSU, 10 immediate, 11 reserved.
- `decoded_immediate`  in  8  constant for CONST.
- `decoded_nzp_write_enable`  in  1  instruction is CMP; latch NZP.
- `alu_out`  in  8  ALU result, registered by the ALU at the EXECUTE edge.
- `lsu_out`  in  8  load data.
- `rs`, `rt`  out  8 each  registered operands.
- `nzp`  out  3  {N,Z,P} flags for the branch unit.

## Operation
- Storage: 16 × 8-bit registers. R0–R12 are general purpose. R13 = %blockIdx, R14 = %blockDim, R15 = %threadIdx.
- Reset values:
  - R0–R12 = 0; R13 = 0; R14 = THREADS_PER_BLOCK[7:0]; R15 = THREAD_ID[7:0].
  - `rs` = `rt` = 0; `nzp` = 000.
- Reset has priority over `enable` and completes in one edge.
- When `enable` = 0, all registers and outputs hold.
- Block index: on every enabled edge with `core_state` = IDLE, R13 <= `block_id`. In all other states R13 holds.
- Read: on an enabled edge with `core_state` = REQUEST:
  - `rs` <= reg[`decoded_rs_address`]; `rt` <= reg[`decoded_rt_address`].
  - Any register, including R13–R15, is readable.
  - In all other states `rs`/`rt` hold.
- Writeback: on an enabled edge with `core_state` = UPDATE and `decoded_reg_write_enable` = 1 and `decoded_rd_address` ≤ 12:
  - mux 00: reg[rd] <= `alu_out`.
  - mux 01: reg[rd] <= `lsu_out`.
  - mux 10: reg[rd] <= `decoded_immediate`.
  - mux 11: no write.
- Writes to R13–R15 are silently dropped.
- NZP: on an enabled edge with `core_state` = UPDATE and `decoded_nzp_write_enable` = 1, `nzp` <= `alu_out[2:0]`. This occurs independently of any register write.
- All data paths are 8-bit with no extension or saturation; values pass unmodified.
- No other state performs reads or writes. FETCH, DECODE, WAIT, EXECUTE and DONE are hold states, except the IDLE R13 capture.

## Timing
- Read latency: 1 cycle. Operands sampled at the REQUEST edge are valid from WAIT onward and stable through EXECUTE and UPDATE, until the next REQUEST.
- Write latency: 1 cycle. A value written at the UPDATE edge is visible to the next instruction's REQUEST read. No bypass is needed because REQUEST and UPDATE never coincide.
- `nzp` updates at the UPDATE edge and is valid for the following instruction's branch evaluation.
- Reset asserted mid-instruction (any state) clears all state at that edge. An in-flight writeback is lost.
- `enable` dropping mid-instruction freezes all state. Re-enabling resumes with the held values.
- `core_state` values outside the listed actions (including DONE) never modify state.

## Test plan
- Reset: after reset, read R0, R13, R14, R15 via REQUEST with THREADS_PER_BLOCK=4, THREAD_ID=2 -> `rs`/`rt` = 0, 0, 4, 2; `nzp` = 000.
- Writeback mux: UPDATE rd=3 with mux 00 `alu_out`=0x2A, then rd=4 with mux 01 `lsu_out`=0x7F, then rd=5 with mux 10 imm=0x05, then rd=6 with mux 11 -> REQUEST reads R3=0x2A, R4=0x7F, R5=0x05, R6=0x00.
- Read-only protect: UPDATE rd=15 with mux 10 imm=0xFF -> R15 still THREAD_ID. IDLE with `block_id`=9 -> R13=9. Later `block_id`=3 in FETCH -> R13 stays 9.
- NZP: UPDATE with nzp_we=1 and `alu_out`=0x04 -> `nzp`=100. Next UPDATE with nzp_we=0 and `alu_out`=0x01 -> `nzp` stays 100.
- Operand stability: REQUEST with rs=3, rt=4 -> `rs`=0x2A, `rt`=0x7F from WAIT onward. Changing the decoded addresses during WAIT/EXECUTE -> outputs unchanged.
- Enable/reset: with `enable`=0, UPDATE rd=2 imm=0x11 -> R2 unchanged. Write R2=0x11 enabled, then reset during EXECUTE -> R2=0, `rs`=0.
